// File: rtl/fft_bf_tf_stage_pkg.sv
// Shared FFT definitions: twiddle format constants and {re, im} helpers.
// Twiddles are signed Q8 (256 = 1.0) and packed as {re[19:10], im[9:0]}.
package fft_bf_tf_stage_pkg;

    localparam int TF_W      = 10;
    localparam int TF_FRAC   = 8;
    localparam int TF_ADDR_W = 7;
    localparam int TF_DATA_W = 2 * TF_W;

    // Real part of a packed twiddle word.
    function automatic logic signed [TF_W-1:0] tf_re(input logic [TF_DATA_W-1:0] tf);
        return tf[TF_DATA_W-1:TF_W];
    endfunction

    // Imaginary part of a packed twiddle word.
    function automatic logic signed [TF_W-1:0] tf_im(input logic [TF_DATA_W-1:0] tf);
        return tf[TF_W-1:0];
    endfunction

    // Pack a twiddle pair back into {re, im}.
    function automatic logic [TF_DATA_W-1:0] tf_pack(input logic signed [TF_W-1:0] re,
                                                     input logic signed [TF_W-1:0] im);
        return {re, im};
    endfunction

endpackage

// File: rtl/fft_cmult_q8.sv
// Complex multiply of operand B by a Q8 twiddle.
// S2: the four partial products are registered when in_valid is set.
// S3: products are combined, optionally rounded, and shifted right by 8;
//     the caller registers the result together with the butterfly add/sub.
// Build option: define TF_ROUND_EN to add 0.5 LSB (round half up) before the
// shift; otherwise the shift truncates toward minus infinity.
module fft_cmult_q8
    import fft_bf_tf_stage_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [2*DW-1:0]      in_b,
    input  logic [TF_DATA_W-1:0] tf_in,
    output logic                 out_valid,
    output logic signed [DW:0]   t_re,
    output logic signed [DW:0]   t_im
);

`ifdef TF_ROUND_EN
    localparam int RND = 1 << (TF_FRAC - 1);
`else
    localparam int RND = 0;
`endif

    logic signed [DW-1:0]   b_re, b_im;
    logic signed [TF_W-1:0] w_re, w_im;
    logic signed [DW+9:0]   p_rr, p_ii, p_ri, p_ir;
    logic signed [DW+10:0]  sum_re, sum_im;

    assign b_re = in_b[2*DW-1:DW];
    assign b_im = in_b[DW-1:0];
    assign w_re = tf_re(tf_in);
    assign w_im = tf_im(tf_in);

    // S2 valid bit follows the incoming valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
        end
    end

    // S2 product registers; the twiddle is only sampled for valid pairs.
    // NOTE: pure datapath registers are left unreset; the valid pipeline qualifies them.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            p_rr <= b_re * w_re;
            p_ii <= b_im * w_im;
            p_ri <= b_re * w_im;
            p_ir <= b_im * w_re;
        end
    end

    // One guard bit for the sum; |W| <= 256 keeps t within DW+1 bits.
    assign sum_re = (DW+11)'(p_rr) - (DW+11)'(p_ii) + (DW+11)'(RND);
    assign sum_im = (DW+11)'(p_ri) + (DW+11)'(p_ir) + (DW+11)'(RND);
    assign t_re   = (DW+1)'(sum_re >>> TF_FRAC);
    assign t_im   = (DW+1)'(sum_im >>> TF_FRAC);

endmodule

// File: rtl/fft_bf_tf_stage.sv
// Pipelined radix-2 DIT butterfly with twiddle ROM addressing.
// The butterfly counter selects k = cnt << (7 - LOG_SPAN); the ROM answers one
// cycle later, in step with the S1 registers. Latency is 3 cycles, throughput
// 1 pair per cycle, no backpressure.
// Build option: TF_ROUND_EN (see fft_cmult_q8) selects rounding of B*W.
module fft_bf_tf_stage
    import fft_bf_tf_stage_pkg::*;
#(
    parameter int DW       = 16,
    parameter int LOG_SPAN = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic                   in_sop,
    input  logic [2*DW-1:0]        in_a,
    input  logic [2*DW-1:0]        in_b,
    output logic [TF_ADDR_W-1:0]   tf_addr,
    output logic                   tf_addr_nd,
    input  logic [TF_DATA_W-1:0]   tf_in,
    output logic                   out_valid,
    output logic [2*(DW+2)-1:0]    out_x,
    output logic [2*(DW+2)-1:0]    out_y
);

    logic [TF_ADDR_W-1:0] k;

    generate
        if (LOG_SPAN == 0) begin : g_no_cnt
            // Single twiddle group: every pair uses k = 0 and in_sop has no effect.
            logic unused_sop;
            assign unused_sop = in_sop;
            assign k          = '0;
        end else begin : g_cnt
            logic [LOG_SPAN-1:0] cnt_q;
            logic [LOG_SPAN-1:0] cnt_cur;

            // A start-of-frame pair uses the cleared count, even at a wrap.
            assign cnt_cur = (in_valid && in_sop) ? '0 : cnt_q;
            assign k       = TF_ADDR_W'(cnt_cur) << (TF_ADDR_W - LOG_SPAN);

            // Butterfly counter: advances once per accepted pair, wraps naturally.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else if (in_valid) begin
                    cnt_q <= cnt_cur + LOG_SPAN'(1);
                end
            end
        end
    endgenerate

    assign tf_addr    = k;
    assign tf_addr_nd = in_valid;

    logic              v_s1, v_s2;
    logic [2*DW-1:0]   a_s1, b_s1, a_s2;
    logic signed [DW:0] t_re, t_im;

    // S1 valid bit, aligned with the ROM read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_s1 <= 1'b0;
        end else begin
            v_s1 <= in_valid;
        end
    end

    // S1/S2 operand registers; A rides alongside the multiplier.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            a_s1 <= in_a;
            b_s1 <= in_b;
        end
        if (v_s1) begin
            a_s2 <= a_s1;
        end
    end

    fft_cmult_q8 #(
        .DW (DW)
    ) u_cmult (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v_s1),
        .in_b      (b_s1),
        .tf_in     (tf_in),
        .out_valid (v_s2),
        .t_re      (t_re),
        .t_im      (t_im)
    );

    logic signed [DW-1:0] a_re, a_im;
    logic signed [DW+1:0] x_re, x_im, y_re, y_im;

    assign a_re = a_s2[2*DW-1:DW];
    assign a_im = a_s2[DW-1:0];
    assign x_re = (DW+2)'(a_re) + (DW+2)'(t_re);
    assign x_im = (DW+2)'(a_im) + (DW+2)'(t_im);
    assign y_re = (DW+2)'(a_re) - (DW+2)'(t_re);
    assign y_im = (DW+2)'(a_im) - (DW+2)'(t_im);

    // S3 output register; outputs hold while no new pair arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
        end else begin
            out_valid <= v_s2;
            if (v_s2) begin
                out_x <= {x_re, x_im};
                out_y <= {y_re, y_im};
            end
        end
    end

endmodule
